control_pipe: RTL and testbench
===============================

Name: control_pipe

Overview:
- Pipelined successor to the single-cycle MIPS-32 control decoder.
- Decodes Opcode/funct in ID and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers.
- Detects data hazards, generating stall and bubble controls and forwarding selects.
- Handles front-end flush on jumps and on taken branches. Sits between the IF/ID register and the datapath stage registers.

Parameters:
- REG_AW, 5, register-address width.
- LINK_REG, 31, destination register for jal.
- FWD_EN, 1, 1 = forwarding plus load-use stall only; 0 = no forwarding, stall on any RAW hazard against EX or MEM.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Opcode  in  6  ID-stage opcode.
- funct  in  6  ID-stage funct.
- rs, rt, rd  in  REG_AW each  ID-stage register fields.
- flush_ex  in  1  branch resolved taken in EX.
- pc_write  out  1  PC enable; 0 while stalling.
- ifid_write  out  1  IF/ID enable; 0 while stalling.
- if_flush  out  1  kill the IF/ID contents.
- id_jump  out  1  j/jal in ID.
- id_jumpreg  out  1  jr/jalr in ID.
- ex_alusrcb  out  1  EX-stage control.
- ex_shamt  out  1  EX-stage control.
- ex_branch  out  1  EX-stage control.
- ex_bne  out  1  EX-stage control.
- ex_link  out  1  EX-stage control.
- ex_aluop  out  6  EX-stage ALU operation code.
- fwd_a, fwd_b  out  2  EX operand selects: 00 regfile, 10 from EX/MEM, 01 from MEM/WB.
- mem_memwrite  out  1  MEM-stage control.
- mem_memread  out  1  MEM-stage control.
- wb_regwrite  out  1  WB-stage control.
- wb_memtoreg  out  1  WB-stage control.
- wb_dst  out  REG_AW  WB write address.

Behaviour:
Decode (combinational, ID stage):
- R-type: Opcode 0.
  - ALUOp = funct.
  - sllv/srlv/srav (funct 0001xx): ALUOp = funct & 111011.
  - jr/jalr: ALUOp = 100000.
  - shamt = (funct[5:2] == 0).
  - dst = rd.
  - RegWrite = 1, except jr (funct 001000).
- I-type ALU (001xxx):
  - slti/sltiu: ALUOp = Opcode + 100000.
  - All others: ALUOp = (Opcode & 110111) + 100000.
  - ALUSrcB = 1; dst = rt; RegWrite = 1.
- lw (100011): ALUOp 100000, ALUSrcB 1, memread, memtoreg, RegWrite, dst = rt.
- sw (101011): ALUOp 100000, ALUSrcB 1, memwrite, no RegWrite.
- beq/bne (00010x): ALUOp 100010, branch; bne = Opcode[0].
- j/jal (00001x): id_jump. jal sets link, RegWrite and dst = LINK_REG.
- jalr sets link and writes rd.
- Unknown opcode: ALUOp 111111, all enables 0 (NOP).
- Source usage:
  - use_rs = 0 for j, jal, sll, srl, sra; 1 otherwise.
  - use_rt = 1 for R-type, branches and sw.
- A dst of 0 forces RegWrite = 0.

Pipeline:
- Bundle decoded in cycle N appears on ex_* at N+1, mem_* at N+2, wb_* at N+3.
- EX/MEM and MEM/WB always advance; there is no back-pressure beyond the ID stall.

Hazards (hazard_unit):
- FWD_EN = 1: stall when EX holds a load, EX.dst != 0 and EX.dst matches rs (use_rs) or rt (use_rt).
- FWD_EN = 0: stall when EX or MEM has RegWrite with a dst != 0 that matches a used source.
- WB needs no stall: the register file writes before it reads.
- During a stall:
  - pc_write = 0, ifid_write = 0.
  - ID/EX loads a bubble (all enables 0, aluop 0).
- Forwarding (FWD_EN = 1) uses the EX-stage rs/rt:
  - EX/MEM match with RegWrite and dst != 0 gives 10; EX/MEM has priority.
  - Otherwise a MEM/WB match gives 01.
  - Otherwise 00.
- FWD_EN = 0: fwd_a and fwd_b are tied to 00.

Flush:
- flush_ex = 1:
  - if_flush = 1.
  - ID/EX loads a bubble.
  - Stall is suppressed: flush wins, so pc_write = ifid_write = 1.
- id_jump or id_jumpreg with no stall: if_flush = 1; the jump itself still enters ID/EX.
- Jump under stall: if_flush is held 0 until the stall releases.

Reset:
- All pipeline registers are cleared: enables 0, aluop 0, dst 0.
- Outputs during and after reset: pc_write = ifid_write = 1, if_flush = 0, fwd = 00.
- Reset mid-operation discards all in-flight bundles on the next edge.

Decomposition:
- Package control_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL) and funct constants (F_JR, F_JALR);
  - the ALUOp constants ALU_ADD = 100000, ALU_SUB = 100010, ALU_NOP = 111111;
  - the fwd-select constants;
  - the packed control-bundle struct typedef.
- One sub-module, hazard_unit, holds the combinational stall and forward logic and takes FWD_EN.

Test Plan:
- Reset, then add $3,$1,$2 → ex_aluop = 100000 one cycle later; wb_regwrite = 1 and wb_dst = 3 three cycles after decode.
- lw $5,0($1) followed by add $6,$5,$2 with FWD_EN = 1 → one cycle of pc_write = 0 and ifid_write = 0, bubble on ex_*; the add then proceeds with fwd_a = 01.
- add $4,.. followed by sub $7,$4,$4 → fwd_a = fwd_b = 10. With FWD_EN = 0 the same pair gives a 2-cycle stall and fwd = 00.
- Writes to $0 (add $0,$1,$2 followed by a use of $0) → no stall, fwd = 00, wb_regwrite = 0.
- jal decoded → id_jump = 1, if_flush = 1, wb_dst = 31 three cycles later. flush_ex asserted together with a load-use stall → if_flush = 1, pc_write = 1, ID/EX bubbled.
- Reset asserted with three instructions in flight → all ex_*, mem_* and wb_* outputs are 0 on the next edge.

Source files
------------

// File: rtl/control_pkg.sv
// Shared encodings and the control bundle carried down the ID/EX, EX/MEM and MEM/WB registers.
package control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_JR     = 6'b001000;
  localparam logic [5:0] F_JALR   = 6'b001001;

  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_SUB  = 6'b100010;
  localparam logic [5:0] ALU_NOP  = 6'b111111;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef struct packed {
    logic       alusrcb;
    logic       shamt;
    logic       branch;
    logic       bne;
    logic       link;
    logic [5:0] aluop;
    logic       memwrite;
    logic       memread;
    logic       regwrite;
    logic       memtoreg;
  } ctrl_t;

endpackage

// File: rtl/hazard_unit.sv
// Combinational stall detection and EX operand forward selection.
module hazard_unit
  import control_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              use_rs,
  input  logic              use_rt,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_dst,
  output logic              stall,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  logic ex_hit, mem_hit;

  always_comb begin
    ex_hit  = (ex_dst != '0) &&
              ((use_rs && (ex_dst == id_rs)) || (use_rt && (ex_dst == id_rt)));
    mem_hit = (mem_dst != '0) &&
              ((use_rs && (mem_dst == id_rs)) || (use_rt && (mem_dst == id_rt)));

    if (FWD_EN) begin
      stall = ex_memread && ex_hit;
    end else begin
      stall = (ex_regwrite && ex_hit) || (mem_regwrite && mem_hit);
    end
  end

  // The older producer sits in MEM/WB, so EX/MEM is checked first to win.
  function automatic logic [1:0] pick(input logic [REG_AW-1:0] src,
                                      input logic              mem_rw,
                                      input logic [REG_AW-1:0] mem_d,
                                      input logic              wb_rw,
                                      input logic [REG_AW-1:0] wb_d);
    if (mem_rw && (mem_d != '0) && (mem_d == src)) return FWD_EXMEM;
    if (wb_rw && (wb_d != '0) && (wb_d == src)) return FWD_MEMWB;
    return FWD_RF;
  endfunction

  always_comb begin
    if (FWD_EN) begin
      fwd_a = pick(ex_rs, mem_regwrite, mem_dst, wb_regwrite, wb_dst);
      fwd_b = pick(ex_rt, mem_regwrite, mem_dst, wb_regwrite, wb_dst);
    end else begin
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
    end
  end

endmodule

// File: rtl/control_pipe.sv
// Pipelined MIPS-32 control: ID decode, control bundle pipeline, stall/flush and forwarding.
module control_pipe
  import control_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LINK_REG = 31,
  parameter bit          FWD_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        Opcode,
  input  logic [5:0]        funct,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic [REG_AW-1:0] rd,
  input  logic              flush_ex,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              if_flush,
  output logic              id_jump,
  output logic              id_jumpreg,
  output logic              ex_alusrcb,
  output logic              ex_shamt,
  output logic              ex_branch,
  output logic              ex_bne,
  output logic              ex_link,
  output logic [5:0]        ex_aluop,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_memwrite,
  output logic              mem_memread,
  output logic              wb_regwrite,
  output logic              wb_memtoreg,
  output logic [REG_AW-1:0] wb_dst
);

  ctrl_t             dec;
  logic [REG_AW-1:0] dec_dst;
  logic              use_rs, use_rt, jump, jumpreg;

  always_comb begin
    dec     = '0;
    dec_dst = '0;
    use_rs  = 1'b1;
    use_rt  = 1'b0;
    jump    = 1'b0;
    jumpreg = 1'b0;
    if (Opcode == OP_RTYPE) begin
      dec.aluop = funct;
      if (funct[5:2] == 4'b0001) dec.aluop = funct & 6'b111011;
      if (funct == F_JR || funct == F_JALR) begin
        dec.aluop = ALU_ADD;
        jumpreg   = 1'b1;
      end
      dec.shamt    = (funct[5:2] == 4'b0000);
      use_rs       = !dec.shamt;
      use_rt       = 1'b1;
      dec_dst      = rd;
      dec.regwrite = (funct != F_JR);
      dec.link     = (funct == F_JALR);
    end else if (Opcode[5:3] == 3'b001) begin
      // slti/sltiu keep their low opcode bits; the rest fold bit 3 away.
      if (Opcode[2:1] == 2'b01) dec.aluop = Opcode + ALU_ADD;
      else                      dec.aluop = (Opcode & 6'b110111) + ALU_ADD;
      dec.alusrcb  = 1'b1;
      dec.regwrite = 1'b1;
      dec_dst      = rt;
    end else begin
      case (Opcode)
        OP_LW: begin
          dec.aluop    = ALU_ADD;
          dec.alusrcb  = 1'b1;
          dec.memread  = 1'b1;
          dec.memtoreg = 1'b1;
          dec.regwrite = 1'b1;
          dec_dst      = rt;
        end
        OP_SW: begin
          dec.aluop    = ALU_ADD;
          dec.alusrcb  = 1'b1;
          dec.memwrite = 1'b1;
          use_rt       = 1'b1;
        end
        OP_BEQ, OP_BNE: begin
          dec.aluop  = ALU_SUB;
          dec.branch = 1'b1;
          dec.bne    = Opcode[0];
          use_rt     = 1'b1;
        end
        OP_J, OP_JAL: begin
          dec.aluop = ALU_ADD;
          jump      = 1'b1;
          use_rs    = 1'b0;
          if (Opcode == OP_JAL) begin
            dec.link     = 1'b1;
            dec.regwrite = 1'b1;
            dec_dst      = REG_AW'(LINK_REG);
          end
        end
        default: dec.aluop = ALU_NOP;
      endcase
    end
    if (dec_dst == '0) dec.regwrite = 1'b0;
  end

  ctrl_t             idex_q, exmem_q, memwb_q;
  logic [REG_AW-1:0] idex_dst_q, idex_rs_q, idex_rt_q, exmem_dst_q, memwb_dst_q;
  logic              stall;
  logic [1:0]        hz_fwd_a, hz_fwd_b;

  hazard_unit #(
    .REG_AW (REG_AW),
    .FWD_EN (FWD_EN)
  ) u_hazard (
    .id_rs        (rs),
    .id_rt        (rt),
    .use_rs       (use_rs),
    .use_rt       (use_rt),
    .ex_regwrite  (idex_q.regwrite),
    .ex_memread   (idex_q.memread),
    .ex_dst       (idex_dst_q),
    .ex_rs        (idex_rs_q),
    .ex_rt        (idex_rt_q),
    .mem_regwrite (exmem_q.regwrite),
    .mem_dst      (exmem_dst_q),
    .wb_regwrite  (memwb_q.regwrite),
    .wb_dst       (memwb_dst_q),
    .stall        (stall),
    .fwd_a        (hz_fwd_a),
    .fwd_b        (hz_fwd_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q      <= '0;
      idex_dst_q  <= '0;
      idex_rs_q   <= '0;
      idex_rt_q   <= '0;
      exmem_q     <= '0;
      exmem_dst_q <= '0;
      memwb_q     <= '0;
      memwb_dst_q <= '0;
    end else begin
      if (stall || flush_ex) begin
        idex_q     <= '0;
        idex_dst_q <= '0;
        idex_rs_q  <= '0;
        idex_rt_q  <= '0;
      end else begin
        idex_q     <= dec;
        idex_dst_q <= dec_dst;
        idex_rs_q  <= rs;
        idex_rt_q  <= rt;
      end
      exmem_q     <= idex_q;
      exmem_dst_q <= idex_dst_q;
      memwb_q     <= exmem_q;
      memwb_dst_q <= exmem_dst_q;
    end
  end

  // A taken branch overrides a stall; the front end is refetched anyway.
  always_comb begin
    pc_write   = rst || !(stall && !flush_ex);
    ifid_write = pc_write;
    if_flush   = !rst && (flush_ex || ((jump || jumpreg) && !stall));
    fwd_a      = rst ? FWD_RF : hz_fwd_a;
    fwd_b      = rst ? FWD_RF : hz_fwd_b;
  end

  assign id_jump      = jump;
  assign id_jumpreg   = jumpreg;
  assign ex_alusrcb   = idex_q.alusrcb;
  assign ex_shamt     = idex_q.shamt;
  assign ex_branch    = idex_q.branch;
  assign ex_bne       = idex_q.bne;
  assign ex_link      = idex_q.link;
  assign ex_aluop     = idex_q.aluop;
  assign mem_memwrite = exmem_q.memwrite;
  assign mem_memread  = exmem_q.memread;
  assign wb_regwrite  = memwb_q.regwrite;
  assign wb_memtoreg  = memwb_q.memtoreg;
  assign wb_dst       = memwb_dst_q;

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: one instance with forwarding, one without.
module tb_control_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic [4:0] rs = '0, rt = '0, rd = '0;
  logic       flush_ex = 1'b0;
  int         errors = 0;
  int         checks = 0;

  logic       f_pc_write, f_ifid_write, f_if_flush, f_id_jump, f_id_jumpreg;
  logic       f_ex_alusrcb, f_ex_shamt, f_ex_branch, f_ex_bne, f_ex_link;
  logic [5:0] f_ex_aluop;
  logic [1:0] f_fwd_a, f_fwd_b;
  logic       f_mem_memwrite, f_mem_memread, f_wb_regwrite, f_wb_memtoreg;
  logic [4:0] f_wb_dst;

  logic       n_pc_write, n_ifid_write, n_if_flush, n_id_jump, n_id_jumpreg;
  logic       n_ex_alusrcb, n_ex_shamt, n_ex_branch, n_ex_bne, n_ex_link;
  logic [5:0] n_ex_aluop;
  logic [1:0] n_fwd_a, n_fwd_b;
  logic       n_mem_memwrite, n_mem_memread, n_wb_regwrite, n_wb_memtoreg;
  logic [4:0] n_wb_dst;

  always #5 clk = ~clk;

  control_pipe #(.REG_AW(5), .LINK_REG(31), .FWD_EN(1'b1)) u_fwd (
    .clk(clk), .rst(rst), .Opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd),
    .flush_ex(flush_ex), .pc_write(f_pc_write), .ifid_write(f_ifid_write),
    .if_flush(f_if_flush), .id_jump(f_id_jump), .id_jumpreg(f_id_jumpreg),
    .ex_alusrcb(f_ex_alusrcb), .ex_shamt(f_ex_shamt), .ex_branch(f_ex_branch),
    .ex_bne(f_ex_bne), .ex_link(f_ex_link), .ex_aluop(f_ex_aluop), .fwd_a(f_fwd_a),
    .fwd_b(f_fwd_b), .mem_memwrite(f_mem_memwrite), .mem_memread(f_mem_memread),
    .wb_regwrite(f_wb_regwrite), .wb_memtoreg(f_wb_memtoreg), .wb_dst(f_wb_dst)
  );

  control_pipe #(.REG_AW(5), .LINK_REG(31), .FWD_EN(1'b0)) u_nofwd (
    .clk(clk), .rst(rst), .Opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd),
    .flush_ex(flush_ex), .pc_write(n_pc_write), .ifid_write(n_ifid_write),
    .if_flush(n_if_flush), .id_jump(n_id_jump), .id_jumpreg(n_id_jumpreg),
    .ex_alusrcb(n_ex_alusrcb), .ex_shamt(n_ex_shamt), .ex_branch(n_ex_branch),
    .ex_bne(n_ex_bne), .ex_link(n_ex_link), .ex_aluop(n_ex_aluop), .fwd_a(n_fwd_a),
    .fwd_b(n_fwd_b), .mem_memwrite(n_mem_memwrite), .mem_memread(n_mem_memread),
    .wb_regwrite(n_wb_regwrite), .wb_memtoreg(n_wb_memtoreg), .wb_dst(n_wb_dst)
  );

  localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, JR = 6'b001000;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, JAL = 6'b000011;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setins(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] s,
                        input logic [4:0] t, input logic [4:0] d);
    opcode = op; funct = fn; rs = s; rt = t; rd = d;
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; flush_ex = 1'b0;
    setins(6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    setins(6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
    tick;
    checks++; if (f_pc_write !== 1'b1) begin errors++; $display("FAIL rst_pc_write got=%b exp=1", f_pc_write); end
    checks++; if (f_ifid_write !== 1'b1) begin errors++; $display("FAIL rst_ifid_write got=%b exp=1", f_ifid_write); end
    checks++; if (f_if_flush !== 1'b0) begin errors++; $display("FAIL rst_if_flush got=%b exp=0", f_if_flush); end
    checks++; if (f_fwd_a !== 2'b00) begin errors++; $display("FAIL rst_fwd_a got=%b exp=00", f_fwd_a); end
    checks++; if (f_ex_aluop !== 6'd0) begin errors++; $display("FAIL rst_ex_aluop got=%b exp=0", f_ex_aluop); end
    checks++; if (f_wb_dst !== 5'd0) begin errors++; $display("FAIL rst_wb_dst got=%0d exp=0", f_wb_dst); end
    rst = 1'b0;
  endtask

  task automatic test_decode;
    do_reset;
    setins(6'd0, ADD, 5'd1, 5'd2, 5'd3);
    tick;
    checks++; if (f_ex_aluop !== 6'b100000) begin errors++; $display("FAIL add_aluop got=%b exp=100000", f_ex_aluop); end
    checks++; if (f_ex_alusrcb !== 1'b0) begin errors++; $display("FAIL add_alusrcb got=%b exp=0", f_ex_alusrcb); end
    setins(6'b001101, 6'd0, 5'd1, 5'd8, 5'd0);  // ori $8,$1
    tick;
    checks++; if (f_ex_aluop !== 6'b100101) begin errors++; $display("FAIL ori_aluop got=%b exp=100101", f_ex_aluop); end
    checks++; if (f_ex_alusrcb !== 1'b1) begin errors++; $display("FAIL ori_alusrcb got=%b exp=1", f_ex_alusrcb); end
    setins(6'd0, 6'b000111, 5'd1, 5'd2, 5'd9);  // srav $9
    tick;
    checks++; if (f_ex_aluop !== 6'b000011) begin errors++; $display("FAIL srav_aluop got=%b exp=000011", f_ex_aluop); end
    checks++; if (f_wb_regwrite !== 1'b1) begin errors++; $display("FAIL add_wb_regwrite got=%b exp=1", f_wb_regwrite); end
    checks++; if (f_wb_dst !== 5'd3) begin errors++; $display("FAIL add_wb_dst got=%0d exp=3", f_wb_dst); end
    setins(6'd0, 6'd0, 5'd0, 5'd2, 5'd10);      // sll $10,$2
    tick;
    checks++; if (f_ex_shamt !== 1'b1) begin errors++; $display("FAIL sll_shamt got=%b exp=1", f_ex_shamt); end
    checks++; if (f_wb_dst !== 5'd8) begin errors++; $display("FAIL ori_wb_dst got=%0d exp=8", f_wb_dst); end
  endtask

  task automatic test_load_use;
    do_reset;
    setins(LW, 6'd0, 5'd1, 5'd5, 5'd0);
    tick;
    setins(6'd0, ADD, 5'd5, 5'd2, 5'd6);
    checks++; if (f_pc_write !== 1'b0) begin errors++; $display("FAIL lu_pc_write got=%b exp=0", f_pc_write); end
    checks++; if (f_ifid_write !== 1'b0) begin errors++; $display("FAIL lu_ifid_write got=%b exp=0", f_ifid_write); end
    tick;
    checks++; if (f_ex_aluop !== 6'd0) begin errors++; $display("FAIL lu_bubble_aluop got=%b exp=0", f_ex_aluop); end
    checks++; if (f_ex_alusrcb !== 1'b0) begin errors++; $display("FAIL lu_bubble_alusrcb got=%b exp=0", f_ex_alusrcb); end
    checks++; if (f_mem_memread !== 1'b1) begin errors++; $display("FAIL lu_mem_memread got=%b exp=1", f_mem_memread); end
    checks++; if (f_pc_write !== 1'b1) begin errors++; $display("FAIL lu_release got=%b exp=1", f_pc_write); end
    tick;
    checks++; if (f_ex_aluop !== ADD) begin errors++; $display("FAIL lu_add_aluop got=%b exp=100000", f_ex_aluop); end
    checks++; if (f_fwd_a !== 2'b01) begin errors++; $display("FAIL lu_fwd_a got=%b exp=01", f_fwd_a); end
    checks++; if (f_fwd_b !== 2'b00) begin errors++; $display("FAIL lu_fwd_b got=%b exp=00", f_fwd_b); end
  endtask

  task automatic test_fwd_ex;
    do_reset;
    setins(6'd0, ADD, 5'd1, 5'd2, 5'd4);
    tick;
    setins(6'd0, SUB, 5'd4, 5'd4, 5'd7);
    checks++; if (f_pc_write !== 1'b1) begin errors++; $display("FAIL fx_pc_write got=%b exp=1", f_pc_write); end
    tick;
    checks++; if (f_ex_aluop !== SUB) begin errors++; $display("FAIL fx_aluop got=%b exp=100010", f_ex_aluop); end
    checks++; if (f_fwd_a !== 2'b10) begin errors++; $display("FAIL fx_fwd_a got=%b exp=10", f_fwd_a); end
    checks++; if (f_fwd_b !== 2'b10) begin errors++; $display("FAIL fx_fwd_b got=%b exp=10", f_fwd_b); end
  endtask

  task automatic test_nofwd;
    int stalls;
    do_reset;
    setins(6'd0, ADD, 5'd1, 5'd2, 5'd4);
    tick;
    setins(6'd0, SUB, 5'd4, 5'd4, 5'd7);
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      if (n_pc_write) break;
      stalls++;
      checks++; if (n_fwd_a !== 2'b00) begin errors++; $display("FAIL nf_stall_fwd_a got=%b exp=00", n_fwd_a); end
      tick;
    end
    checks++; if (stalls != 2) begin errors++; $display("FAIL nf_stall_cycles got=%0d exp=2", stalls); end
    tick;
    checks++; if (n_ex_aluop !== SUB) begin errors++; $display("FAIL nf_aluop got=%b exp=100010", n_ex_aluop); end
    checks++; if (n_fwd_a !== 2'b00) begin errors++; $display("FAIL nf_fwd_a got=%b exp=00", n_fwd_a); end
    checks++; if (n_fwd_b !== 2'b00) begin errors++; $display("FAIL nf_fwd_b got=%b exp=00", n_fwd_b); end
  endtask

  task automatic test_zero_dst;
    do_reset;
    setins(6'd0, ADD, 5'd1, 5'd2, 5'd0);
    tick;
    setins(6'd0, ADD, 5'd0, 5'd0, 5'd9);
    checks++; if (f_pc_write !== 1'b1) begin errors++; $display("FAIL z_fwd_pc_write got=%b exp=1", f_pc_write); end
    checks++; if (n_pc_write !== 1'b1) begin errors++; $display("FAIL z_nofwd_pc_write got=%b exp=1", n_pc_write); end
    tick;
    checks++; if (f_fwd_a !== 2'b00) begin errors++; $display("FAIL z_fwd_a got=%b exp=00", f_fwd_a); end
    checks++; if (f_fwd_b !== 2'b00) begin errors++; $display("FAIL z_fwd_b got=%b exp=00", f_fwd_b); end
    setins(6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
    tick;
    checks++; if (f_wb_regwrite !== 1'b0) begin errors++; $display("FAIL z_wb_regwrite got=%b exp=0", f_wb_regwrite); end
  endtask

  task automatic test_jump;
    do_reset;
    setins(JAL, 6'd0, 5'd0, 5'd0, 5'd0);
    checks++; if (f_id_jump !== 1'b1) begin errors++; $display("FAIL jal_id_jump got=%b exp=1", f_id_jump); end
    checks++; if (f_if_flush !== 1'b1) begin errors++; $display("FAIL jal_if_flush got=%b exp=1", f_if_flush); end
    tick;
    checks++; if (f_ex_link !== 1'b1) begin errors++; $display("FAIL jal_ex_link got=%b exp=1", f_ex_link); end
    setins(6'd0, JR, 5'd31, 5'd0, 5'd0);
    checks++; if (f_id_jumpreg !== 1'b1) begin errors++; $display("FAIL jr_id_jumpreg got=%b exp=1", f_id_jumpreg); end
    checks++; if (f_if_flush !== 1'b1) begin errors++; $display("FAIL jr_if_flush got=%b exp=1", f_if_flush); end
    tick;
    checks++; if (f_ex_aluop !== ADD) begin errors++; $display("FAIL jr_aluop got=%b exp=100000", f_ex_aluop); end
    setins(6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
    tick;
    checks++; if (f_wb_dst !== 5'd31) begin errors++; $display("FAIL jal_wb_dst got=%0d exp=31", f_wb_dst); end
    checks++; if (f_wb_regwrite !== 1'b1) begin errors++; $display("FAIL jal_wb_regwrite got=%b exp=1", f_wb_regwrite); end
  endtask

  task automatic test_flush_stall;
    do_reset;
    setins(LW, 6'd0, 5'd1, 5'd5, 5'd0);
    tick;
    flush_ex = 1'b1;
    setins(6'd0, ADD, 5'd5, 5'd2, 5'd6);
    checks++; if (f_if_flush !== 1'b1) begin errors++; $display("FAIL fs_if_flush got=%b exp=1", f_if_flush); end
    checks++; if (f_pc_write !== 1'b1) begin errors++; $display("FAIL fs_pc_write got=%b exp=1", f_pc_write); end
    checks++; if (f_ifid_write !== 1'b1) begin errors++; $display("FAIL fs_ifid_write got=%b exp=1", f_ifid_write); end
    tick;
    flush_ex = 1'b0;
    checks++; if (f_ex_aluop !== 6'd0) begin errors++; $display("FAIL fs_bubble_aluop got=%b exp=0", f_ex_aluop); end
    setins(LW, 6'd0, 5'd1, 5'd5, 5'd0);
    tick;
    setins(6'd0, JR, 5'd5, 5'd0, 5'd0);
    checks++; if (f_if_flush !== 1'b0) begin errors++; $display("FAIL js_held got=%b exp=0", f_if_flush); end
    checks++; if (f_pc_write !== 1'b0) begin errors++; $display("FAIL js_pc_write got=%b exp=0", f_pc_write); end
    tick;
    checks++; if (f_if_flush !== 1'b1) begin errors++; $display("FAIL js_release got=%b exp=1", f_if_flush); end
  endtask

  task automatic test_reset_midflight;
    do_reset;
    setins(6'd0, ADD, 5'd1, 5'd2, 5'd3);
    tick;
    setins(LW, 6'd0, 5'd1, 5'd5, 5'd0);
    tick;
    setins(SW, 6'd0, 5'd1, 5'd2, 5'd0);
    tick;
    checks++; if (f_mem_memread !== 1'b1) begin errors++; $display("FAIL mf_pre_memread got=%b exp=1", f_mem_memread); end
    checks++; if (f_wb_regwrite !== 1'b1) begin errors++; $display("FAIL mf_pre_regwrite got=%b exp=1", f_wb_regwrite); end
    rst = 1'b1;
    setins(JAL, 6'd0, 5'd0, 5'd0, 5'd0);
    checks++; if (f_if_flush !== 1'b0) begin errors++; $display("FAIL mf_rst_if_flush got=%b exp=0", f_if_flush); end
    tick;
    checks++; if (f_ex_alusrcb !== 1'b0) begin errors++; $display("FAIL mf_ex_alusrcb got=%b exp=0", f_ex_alusrcb); end
    checks++; if (f_ex_aluop !== 6'd0) begin errors++; $display("FAIL mf_ex_aluop got=%b exp=0", f_ex_aluop); end
    checks++; if (f_mem_memwrite !== 1'b0) begin errors++; $display("FAIL mf_memwrite got=%b exp=0", f_mem_memwrite); end
    checks++; if (f_mem_memread !== 1'b0) begin errors++; $display("FAIL mf_memread got=%b exp=0", f_mem_memread); end
    checks++; if (f_wb_regwrite !== 1'b0) begin errors++; $display("FAIL mf_wb_regwrite got=%b exp=0", f_wb_regwrite); end
    checks++; if (f_wb_dst !== 5'd0) begin errors++; $display("FAIL mf_wb_dst got=%0d exp=0", f_wb_dst); end
    checks++; if (f_pc_write !== 1'b1) begin errors++; $display("FAIL mf_pc_write got=%b exp=1", f_pc_write); end
    rst = 1'b0;
  endtask

  initial begin
    test_reset;
    test_decode;
    test_load_use;
    test_fwd_ex;
    test_nofwd;
    test_zero_dst;
    test_jump;
    test_flush_stall;
    test_reset_midflight;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
